// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC and state encoding for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  // A fetch address that is not word aligned cannot be sent to memory.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, single-outstanding imem reads,
// redirect handling with stale-response kill, valid/ready toward decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_err_o
);

  ifu_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;
  logic              err_q;
  logic              kill_q;
  logic              req_valid_q;
  logic              inst_valid_q;

  logic              go_req;
  logic [ADDR_W-1:0] tgt_pc;

  // Decide whether a new fetch starts this cycle and from which PC.
  always_comb begin
    go_req = 1'b0;
    tgt_pc = pc_q;
    case (state_q)
      IFU_IDLE: begin
        go_req = 1'b1;
        if (redirect_valid_i) tgt_pc = redirect_pc_i;
      end
      IFU_WAIT: begin
        if (imem_rsp_valid_i && (kill_q || redirect_valid_i)) begin
          go_req = 1'b1;
          if (redirect_valid_i) tgt_pc = redirect_pc_i;
        end
      end
      IFU_HOLD: begin
        if (redirect_valid_i) begin
          go_req = 1'b1;
          tgt_pc = redirect_pc_i;
        end else if (inst_ready_i) begin
          go_req = 1'b1;
          tgt_pc = pc_q + PC_STEP;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM, PC register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      inst_q       <= '0;
      err_q        <= 1'b0;
      kill_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else if (go_req) begin
      pc_q   <= tgt_pc;
      kill_q <= 1'b0;
      if (is_misaligned(tgt_pc)) begin
        // Fault is reported locally; memory never sees the bad address.
        state_q      <= IFU_HOLD;
        inst_q       <= '0;
        err_q        <= 1'b1;
        req_valid_q  <= 1'b0;
        inst_valid_q <= 1'b1;
      end else begin
        state_q      <= IFU_REQ;
        addr_q       <= tgt_pc;
        req_valid_q  <= 1'b1;
        inst_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        IFU_REQ: begin
          // Request address stays put; the fetch in flight becomes stale.
          if (redirect_valid_i) begin
            pc_q   <= redirect_pc_i;
            kill_q <= 1'b1;
          end
          if (imem_req_ready_i) begin
            state_q     <= IFU_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        IFU_WAIT: begin
          if (redirect_valid_i) begin
            pc_q   <= redirect_pc_i;
            kill_q <= 1'b1;
          end else if (imem_rsp_valid_i) begin
            state_q      <= IFU_HOLD;
            inst_q       <= imem_rsp_data_i;
            err_q        <= imem_rsp_err_i;
            inst_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_addr_o      = addr_q;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign pc_o             = pc_q;
  assign fetch_err_o      = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed stimulus pushes expected requests
// and instructions; negedge monitors pop and compare on each handshake.
module tb_ifu_fetch;

  logic        clk;
  logic        reset;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;

  ifu_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .fetch_err_o      (fetch_err_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_inst_t;

  exp_inst_t   exp_inst_q[$];
  logic [31:0] exp_req_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int req_hs  = 0;
  int inst_hs = 0;
  int inst_cyc[2];
  int rsp_lat = 0;
  int n0;

  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] mon_req_e;
  exp_inst_t   mon_inst_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  // Instruction memory contents used by the directed tests.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_000C: return 32'hDEAD_BEEF;
      32'h8000_1000: return 32'h0010_0093;
      32'h8000_3000: return 32'h1234_5678;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a == 32'h8000_3000;
  endfunction

  // Memory model: one response per accepted request, rsp_lat extra cycles.
  always @(negedge clk) begin
    imem_rsp_valid_i = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i  = mem_word(pend_addr);
          imem_rsp_err_i   = mem_err(pend_addr);
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        pend      = 1'b1;
        pend_cnt  = rsp_lat;
        pend_addr = imem_addr_o;
      end
    end
  end

  // Request monitor: every accepted request must match the next expected address.
  always @(negedge clk) begin
    if (!reset && imem_req_valid_o && imem_req_ready_i) begin
      req_hs++;
      if (exp_req_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_req actual=%h required=none", imem_addr_o);
      end else begin
        mon_req_e = exp_req_q.pop_front();
        check("req_addr", imem_addr_o, mon_req_e);
      end
    end
  end

  // Instruction monitor: every consumed instruction must match the scoreboard.
  always @(negedge clk) begin
    if (!reset && inst_valid_o && inst_ready_i) begin
      if (inst_hs < 2) inst_cyc[inst_hs] = cyc;
      inst_hs++;
      if (exp_inst_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_inst actual_pc=%h actual_inst=%h required=none", pc_o, inst_o);
      end else begin
        mon_inst_e = exp_inst_q.pop_front();
        check("inst_pc", pc_o, mon_inst_e.pc);
        check("inst_word", inst_o, mon_inst_e.inst);
        check("inst_err", 32'(fetch_err_o), 32'(mon_inst_e.err));
      end
    end
  end

  task automatic push_inst(input logic [31:0] pc, input logic [31:0] inst, input logic err);
    exp_inst_t e;
    e.pc = pc; e.inst = inst; e.err = err;
    exp_inst_q.push_back(e);
  endtask

  task automatic wait_inst_valid(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (inst_valid_o) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL timeout_inst_valid actual=0 required=1");
    end
  endtask

  task automatic wait_req_hs(input int target, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (req_hs >= target) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL timeout_req_hs actual=%0d required=%0d", req_hs, target);
    end
  endtask

  task automatic wait_inst_hs(input int target, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (inst_hs >= target) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL timeout_inst_hs actual=%0d required=%0d", inst_hs, target);
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    @(posedge clk); #1;
    redirect_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h8000_0000);
    check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_err", 32'(fetch_err_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    imem_rsp_err_i   = 1'b0;
    inst_ready_i     = 1'b1;

    // Straight-line fetch, then stall on the third instruction.
    exp_req_q.push_back(32'h8000_0000);
    exp_req_q.push_back(32'h8000_0004);
    exp_req_q.push_back(32'h8000_0008);
    exp_req_q.push_back(32'h8000_000C);
    push_inst(32'h8000_0000, 32'h0000_0013, 1'b0);
    push_inst(32'h8000_0004, 32'h0000_0013, 1'b0);
    push_inst(32'h8000_0008, 32'h0000_0013, 1'b0);

    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_req_idle", 32'(imem_req_valid_o), 32'd0);
    @(negedge clk);
    check("first_req_cycle2", 32'(imem_req_valid_o), 32'd1);

    wait_inst_hs(2, 40);
    check("inst_period", 32'(inst_cyc[1] - inst_cyc[0]), 32'd3);
    @(posedge clk); #1;
    inst_ready_i = 1'b0;

    // Decode back-pressure: instruction and PC hold, no new request.
    wait_inst_valid(40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_inst", inst_o, 32'h0000_0013);
      check("stall_pc", pc_o, 32'h8000_0008);
      check("stall_no_req", 32'(imem_req_valid_o), 32'd0);
    end
    rsp_lat = 2;
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    @(posedge clk); #1;
    inst_ready_i = 1'b0;

    // Redirect while the 0x8000000C fetch is outstanding: stale word dropped.
    wait_req_hs(4, 20);
    @(posedge clk); #1;
    exp_req_q.push_back(32'h8000_1000);
    pulse_redirect(32'h8000_1000);
    rsp_lat = 0;
    wait_inst_valid(40);
    check("redir_inst", inst_o, 32'h0010_0093);
    check("redir_pc", pc_o, 32'h8000_1000);
    check("redir_err", 32'(fetch_err_o), 32'd0);

    // Redirect and handshake in the same cycle: redirect target wins over +4.
    push_inst(32'h8000_1000, 32'h0010_0093, 1'b0);
    exp_req_q.push_back(32'h8000_2000);
    @(posedge clk); #1;
    inst_ready_i     = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_2000;
    @(posedge clk); #1;
    inst_ready_i     = 1'b0;
    redirect_valid_i = 1'b0;
    wait_inst_valid(40);
    check("hs_redir_pc", pc_o, 32'h8000_2000);

    // Misaligned redirect faults locally; then an access-fault response.
    push_inst(32'h8000_0002, 32'h0000_0000, 1'b1);
    exp_req_q.push_back(32'h8000_3000);
    push_inst(32'h8000_3000, 32'h1234_5678, 1'b1);
    exp_req_q.push_back(32'h8000_3004);
    @(posedge clk); #1;
    pulse_redirect(32'h8000_0002);
    @(negedge clk);
    check("misal_valid", 32'(inst_valid_o), 32'd1);
    check("misal_err", 32'(fetch_err_o), 32'd1);
    check("misal_inst", inst_o, 32'd0);
    check("misal_no_req", 32'(imem_req_valid_o), 32'd0);
    @(posedge clk); #1;
    inst_ready_i     = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_3000;
    @(posedge clk); #1;
    inst_ready_i     = 1'b0;
    redirect_valid_i = 1'b0;
    wait_inst_valid(40);
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    @(posedge clk); #1;
    inst_ready_i = 1'b0;

    // PC wrap from the top of the address space, then reset during WAIT.
    wait_inst_valid(40);
    @(posedge clk); #1;
    exp_req_q.push_back(32'hFFFF_FFFC);
    push_inst(32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
    exp_req_q.push_back(32'h0000_0000);
    pulse_redirect(32'hFFFF_FFFC);
    wait_inst_valid(40);
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    rsp_lat = 3;
    n0 = req_hs;
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    @(posedge clk); #1;
    inst_ready_i = 1'b0;
    wait_req_hs(n0 + 1, 20);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    exp_req_q.push_back(32'h8000_0000);
    @(posedge clk); #1;
    reset   = 1'b0;
    rsp_lat = 0;
    wait_req_hs(n0 + 2, 20);
    @(posedge clk); #1;
    imem_req_ready_i = 1'b0;
    repeat (8) @(negedge clk);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
